// File: rtl/instruction_fetch_pkg.sv
// Shared CPU definitions used by the fetch and decode stages.
package instruction_fetch_pkg;

  localparam int unsigned CPU_INSTR_WIDTH = 32;
  localparam int unsigned CPU_PC_WIDTH    = 8;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FLUSH,
    HALTED
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: stores fetched words with their addresses, head is read combinationally.
module fetch_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   pushData,
  input  logic [ADDR_WIDTH-1:0]   pushAddr,
  input  logic                    pop,
  output logic [DATA_WIDTH-1:0]   headData,
  output logic [ADDR_WIDTH-1:0]   headAddr,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int unsigned PTR_WIDTH = $clog2(DEPTH);
  localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] dataMem [DEPTH];
  logic [ADDR_WIDTH-1:0] addrMem [DEPTH];
  logic [PTR_WIDTH-1:0]  wrPtr;
  logic [PTR_WIDTH-1:0]  rdPtr;

  // Entry storage; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (push) begin
      dataMem[wrPtr] <= pushData;
      addrMem[wrPtr] <= pushAddr;
    end
  end

  // Pointer and occupancy bookkeeping; a simultaneous push and pop keeps the count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head view and status flags.
  always_comb begin
    headData = dataMem[rdPtr];
    headAddr = addrMem[rdPtr];
    full     = (count == FULL_COUNT);
    empty    = (count == '0);
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: credit-limited prefetch into a small FIFO with branch flush.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned          INSTRUCTION_WIDTH = CPU_INSTR_WIDTH,
  parameter int unsigned          PC_WIDTH          = CPU_PC_WIDTH,
  parameter int unsigned          FIFO_DEPTH        = 4,
  parameter logic [PC_WIDTH-1:0]  RESET_PC          = '0
) (
  input  logic                          clock,
  input  logic                          reset,
  output logic                          memRead,
  output logic [PC_WIDTH-1:0]           memAddress,
  input  logic                          memReady,
  input  logic                          memDataValid,
  input  logic [INSTRUCTION_WIDTH-1:0]  memData,
  output logic [INSTRUCTION_WIDTH-1:0]  instruction,
  output logic [PC_WIDTH-1:0]           instructionPc,
  output logic                          instructionValid,
  input  logic                          instructionReady,
  input  logic                          branchTaken,
  input  logic [PC_WIDTH-1:0]           branchTarget,
  input  logic                          halt
);

  localparam int unsigned CNT_WIDTH = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_WIDTH:0]   DEPTH_L = (CNT_WIDTH + 1)'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

  fetch_state_t state;
  fetch_state_t stateNext;

  logic [PC_WIDTH-1:0]          fetchPc;
  logic [PC_WIDTH-1:0]          respPc;
  logic [CNT_WIDTH-1:0]         outstanding;
  logic [CNT_WIDTH-1:0]         outstandingNext;
  logic [CNT_WIDTH-1:0]         dropCount;
  logic [CNT_WIDTH-1:0]         fifoCount;
  logic [INSTRUCTION_WIDTH-1:0] headData;
  logic [PC_WIDTH-1:0]          headAddr;
  logic                         fifoFull;
  logic                         fifoEmpty;
  logic                         fifoPush;
  logic                         fifoPop;
  logic                         accept;
  logic                         redirect;
  logic                         credit;

  // Handshakes and credit; responses are only kept outside FLUSH and never on a redirect cycle.
  always_comb begin
    credit   = ({1'b0, fifoCount} + {1'b0, outstanding}) < DEPTH_L;
    accept   = memRead && memReady;
    redirect = branchTaken && (state != IDLE);
    fifoPop  = !fifoEmpty && instructionReady && !redirect;
    fifoPush = memDataValid && !redirect && (state == FETCH || state == HALTED)
               && (!fifoFull || fifoPop);
    outstandingNext = outstanding;
    if (accept && !memDataValid)
      outstandingNext = outstanding + 1'b1;
    else if (!accept && memDataValid && outstanding != '0)
      outstandingNext = outstanding - 1'b1;
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state logic; a redirect overrides every other transition.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:   stateNext = FETCH;
      FETCH:  if (halt) stateNext = HALTED;
      HALTED: if (!halt) stateNext = FETCH;
      FLUSH:  if (memDataValid && dropCount == ONE) stateNext = halt ? HALTED : FETCH;
    endcase
    if (redirect) stateNext = (outstandingNext != '0) ? FLUSH : FETCH;
  end

  // Output logic: requests only in FETCH with halt low and buffer credit available.
  always_comb begin
    memRead          = (state == FETCH) && !halt && credit;
    memAddress       = fetchPc;
    instructionValid = !fifoEmpty;
    instruction      = instructionValid ? headData : '0;
    instructionPc    = instructionValid ? headAddr : '0;
  end

  // Fetch/response address tracking, outstanding credits and stale-response drop count.
  // respPc restarts at the target on a redirect: every response still in flight at that
  // point is stale and dropped, so the next kept response belongs to branchTarget.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetchPc     <= RESET_PC;
      respPc      <= RESET_PC;
      outstanding <= '0;
      dropCount   <= '0;
    end else begin
      outstanding <= outstandingNext;
      if (redirect) begin
        fetchPc   <= branchTarget;
        respPc    <= branchTarget;
        dropCount <= outstandingNext;
      end else begin
        if (accept)   fetchPc <= fetchPc + 1'b1;
        if (fifoPush) respPc  <= respPc + 1'b1;
        if (state == FLUSH && memDataValid && dropCount != '0)
          dropCount <= dropCount - 1'b1;
      end
    end
  end

  fetch_fifo #(
    .DATA_WIDTH (INSTRUCTION_WIDTH),
    .ADDR_WIDTH (PC_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .clear    (redirect),
    .push     (fifoPush),
    .pushData (memData),
    .pushAddr (respPc),
    .pop      (fifoPop),
    .headData (headData),
    .headAddr (headAddr),
    .count    (fifoCount),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch with an epoch-based reference model and memory model.
module tb_instruction_fetch;

  localparam int unsigned DEPTH    = 4;
  localparam logic [7:0]  RST_PC   = 8'h00;

  logic        clock;
  logic        reset;
  logic        memRead;
  logic [7:0]  memAddress;
  logic        memReady;
  logic        memDataValid;
  logic [31:0] memData;
  logic [31:0] instruction;
  logic [7:0]  instructionPc;
  logic        instructionValid;
  logic        instructionReady;
  logic        branchTaken;
  logic [7:0]  branchTarget;
  logic        halt;

  instruction_fetch #(
    .INSTRUCTION_WIDTH (32),
    .PC_WIDTH          (8),
    .FIFO_DEPTH        (DEPTH),
    .RESET_PC          (RST_PC)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .memRead          (memRead),
    .memAddress       (memAddress),
    .memReady         (memReady),
    .memDataValid     (memDataValid),
    .memData          (memData),
    .instruction      (instruction),
    .instructionPc    (instructionPc),
    .instructionValid (instructionValid),
    .instructionReady (instructionReady),
    .branchTaken      (branchTaken),
    .branchTarget     (branchTarget),
    .halt             (halt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  addr;
    int unsigned epoch;
    int unsigned due;
  } req_t;

  req_t        memq[$];   // requests accepted by memory, in order
  logic [7:0]  fq[$];     // addresses the decode stage should see, in order
  int unsigned epoch;
  logic [7:0]  expPc;
  bit          haltPrev;
  int unsigned cyc;
  int unsigned lastDue;

  int unsigned latMin, latMax, pReady, pIR, pBranch, pHalt;
  bit          forceBranch, forceReadyLow;
  logic [7:0]  forceTarget;

  int unsigned acceptCount, firstAcceptCyc, firstValidCyc;
  bit          sawPc40;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] word(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A, a + 8'h33};
  endfunction

  task automatic reset_dut();
    reset            = 1'b1;
    branchTaken      = 1'b0;
    branchTarget     = '0;
    halt             = 1'b0;
    memReady         = 1'b0;
    memDataValid     = 1'b0;
    memData          = '0;
    instructionReady = 1'b0;
    #1;
    check("rstMemRead", memRead, 0);
    check("rstValid", instructionValid, 0);
    check("rstMemAddress", memAddress, RST_PC);
    check("rstInstruction", instruction, 0);
    check("rstInstructionPc", instructionPc, 0);
    memq.delete();
    fq.delete();
    expPc          = RST_PC;
    haltPrev       = 1'b0;
    lastDue        = cyc;
    acceptCount    = 0;
    firstAcceptCyc = 0;
    firstValidCyc  = 0;
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic step();
    req_t        r;
    bit          flushing, expRead, acc, rsp, pp;
    int unsigned lat, due;
    @(posedge clock);
    #1;
    cyc++;
    if (halt) halt = ($urandom_range(99) < 60);
    else      halt = ($urandom_range(99) < pHalt);
    instructionReady = ($urandom_range(99) < pIR);
    memReady         = forceReadyLow ? 1'b0 : ($urandom_range(99) < pReady);
    branchTaken      = forceBranch || ($urandom_range(999) < pBranch);
    branchTarget     = forceBranch ? forceTarget : 8'($urandom);
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      memDataValid = 1'b1;
      memData      = word(memq[0].addr);
    end else begin
      memDataValid = 1'b0;
      memData      = $urandom;
    end
    forceBranch   = 1'b0;
    forceReadyLow = 1'b0;

    @(negedge clock);
    check("instructionValid", instructionValid, fq.size() > 0);
    if (fq.size() > 0) begin
      check("instructionPc", instructionPc, fq[0]);
      check("instruction", instruction, word(fq[0]));
    end
    flushing = 1'b0;
    foreach (memq[i]) if (memq[i].epoch != epoch) flushing = 1'b1;
    expRead = !flushing && !halt && (fq.size() + memq.size() < DEPTH);
    if (!haltPrev || halt) check("memRead", memRead, expRead);
    if (memRead) check("memAddress", memAddress, expPc);
    if (instructionValid && firstValidCyc == 0) firstValidCyc = cyc;
    if (instructionValid && instructionPc == 8'h40) sawPc40 = 1'b1;

    acc = memRead && memReady;
    rsp = memDataValid;
    pp  = (fq.size() > 0) && instructionReady && !branchTaken;
    if (acc) begin
      acceptCount++;
      if (firstAcceptCyc == 0) firstAcceptCyc = cyc;
    end
    if (pp) void'(fq.pop_front());
    if (rsp) begin
      r = memq.pop_front();
      if (!branchTaken && r.epoch == epoch) fq.push_back(r.addr);
    end
    if (acc) begin
      lat = $urandom_range(latMax, latMin);
      due = cyc + lat;
      if (due <= lastDue) due = lastDue + 1;
      lastDue = due;
      memq.push_back('{expPc, epoch, due});
      expPc = expPc + 8'd1;
    end
    if (branchTaken) begin
      fq.delete();
      epoch++;
      expPc = branchTarget;
    end
    haltPrev = halt;
  endtask

  task automatic set_knobs(input int unsigned lmin, input int unsigned lmax,
                           input int unsigned rdy, input int unsigned ir,
                           input int unsigned br, input int unsigned hl);
    latMin = lmin; latMax = lmax; pReady = rdy; pIR = ir; pBranch = br; pHalt = hl;
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  initial begin
    cyc = 0; epoch = 0; sawPc40 = 1'b0;
    forceBranch = 1'b0; forceReadyLow = 1'b0; forceTarget = '0;
    set_knobs(1, 1, 100, 100, 0, 0);
    reset_dut();

    // Streaming with a 1-cycle memory: back-to-back requests, 2-cycle fetch latency.
    run(12);
    check("firstLatency", firstValidCyc - firstAcceptCyc, 2);

    // Stalled decode: credits cap requests at the buffer depth; one pop frees one.
    reset_dut();
    set_knobs(1, 1, 100, 0, 0, 0);
    run(10);
    check("acceptsWhenFull", acceptCount, 4);
    pIR = 100;
    run(1);
    pIR = 0;
    run(6);
    check("acceptsAfterPop", acceptCount, 5);

    // 3-cycle memory, two outstanding, redirect to 0x40.
    reset_dut();
    set_knobs(3, 3, 100, 100, 0, 0);
    sawPc40 = 1'b0;
    run(2);
    forceBranch = 1'b1; forceTarget = 8'h40; forceReadyLow = 1'b1;
    run(1);
    check("validAfterBranch", instructionValid, 0);
    run(15);
    check("sawPc40", sawPc40, 1);

    // Redirect coinciding with an accept and a response.
    set_knobs(1, 1, 100, 100, 0, 0);
    run(6);
    forceBranch = 1'b1; forceTarget = 8'h80;
    run(10);

    // Address wrap past 0xFF.
    forceBranch = 1'b1; forceTarget = 8'hFD;
    run(10);

    // Reset while flushing two stale responses.
    reset_dut();
    set_knobs(3, 3, 100, 100, 0, 0);
    run(2);
    forceBranch = 1'b1; forceTarget = 8'h40; forceReadyLow = 1'b1;
    run(2);
    #2;
    reset_dut();
    set_knobs(1, 1, 100, 100, 0, 0);
    run(8);

    // Randomized operation.
    for (int unsigned b = 0; b < 16; b++) begin
      set_knobs(1, $urandom_range(4, 1), $urandom_range(100, 30), $urandom_range(100, 20),
                $urandom_range(60, 0), $urandom_range(10, 0));
      run(250);
      if (b % 4 == 3) begin
        #2;
        reset_dut();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
